// File: rtl/mem_arb.sv
`default_nettype none
// ============================================================================
//  Module   : mem_arb
//  Purpose  : Shares one memory port between instruction fetch and load/store,
//             with one transaction outstanding and responses routed to owner.
//  Revision : 1.0 - initial release
// ============================================================================
module mem_arb #(
    parameter int AW = 32,
    parameter int DW = 32,
    parameter int RR = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_req,
    input  logic [AW-1:0]     i_addr,
    output logic              i_gnt,
    output logic              i_rvalid,
    output logic [DW-1:0]     i_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [AW-1:0]     d_addr,
    input  logic [DW-1:0]     d_wdata,
    input  logic [DW/8-1:0]   d_wstrb,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [DW-1:0]     d_rdata,
    output logic              m_req,
    output logic              m_we,
    output logic [AW-1:0]     m_addr,
    output logic [DW-1:0]     m_wdata,
    output logic [DW/8-1:0]   m_wstrb,
    input  logic              m_ready,
    input  logic              m_rvalid,
    input  logic [DW-1:0]     m_rdata
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    logic [1:0]       r_state;
    logic             r_last_d;
    logic             r_own_d;
    logic             r_m_req;
    logic             r_m_we;
    logic [AW-1:0]    r_m_addr;
    logic [DW-1:0]    r_m_wdata;
    logic [DW/8-1:0]  r_m_wstrb;
    logic             r_i_rvalid;
    logic [DW-1:0]    r_i_rdata;
    logic             r_d_rvalid;
    logic [DW-1:0]    r_d_rdata;
    logic             w_gnt_i;
    logic             w_gnt_d;

    // Grants are only offered from IDLE and never while reset is held.
    always_comb begin
        w_gnt_i = 1'b0;
        w_gnt_d = 1'b0;
        if (rst && (r_state == S_IDLE)) begin
            if (i_req && d_req) begin
                if (RR != 0) begin
                    w_gnt_i = r_last_d;
                    w_gnt_d = !r_last_d;
                end else begin
                    w_gnt_d = 1'b1;
                end
            end else begin
                w_gnt_i = i_req;
                w_gnt_d = d_req;
            end
        end
    end

    // r_last_d resets to 1 so the fetch side wins the first tie after reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= S_IDLE;
            r_last_d   <= 1'b1;
            r_own_d    <= 1'b0;
            r_m_req    <= 1'b0;
            r_m_we     <= 1'b0;
            r_m_addr   <= '0;
            r_m_wdata  <= '0;
            r_m_wstrb  <= '0;
            r_i_rvalid <= 1'b0;
            r_i_rdata  <= '0;
            r_d_rvalid <= 1'b0;
            r_d_rdata  <= '0;
        end else begin
            r_i_rvalid <= 1'b0;
            r_d_rvalid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_gnt_i || w_gnt_d) begin
                        r_state  <= S_REQ;
                        r_m_req  <= 1'b1;
                        r_own_d  <= w_gnt_d;
                        r_last_d <= w_gnt_d;
                        if (w_gnt_d) begin
                            r_m_we    <= d_we;
                            r_m_addr  <= d_addr;
                            r_m_wdata <= d_we ? d_wdata : '0;
                            r_m_wstrb <= d_we ? d_wstrb : '0;
                        end else begin
                            r_m_we    <= 1'b0;
                            r_m_addr  <= i_addr;
                            r_m_wdata <= '0;
                            r_m_wstrb <= '0;
                        end
                    end
                end
                S_REQ: begin
                    if (m_ready) begin
                        r_m_req <= 1'b0;
                        r_state <= S_RESP;
                    end
                end
                S_RESP: begin
                    if (m_rvalid) begin
                        r_state <= S_IDLE;
                        if (r_own_d) begin
                            r_d_rvalid <= 1'b1;
                            r_d_rdata  <= r_m_we ? '0 : m_rdata;
                        end else begin
                            r_i_rvalid <= 1'b1;
                            r_i_rdata  <= m_rdata;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign i_gnt    = w_gnt_i;
    assign d_gnt    = w_gnt_d;
    assign i_rvalid = r_i_rvalid;
    assign i_rdata  = r_i_rdata;
    assign d_rvalid = r_d_rvalid;
    assign d_rdata  = r_d_rdata;
    assign m_req    = r_m_req;
    assign m_we     = r_m_we;
    assign m_addr   = r_m_addr;
    assign m_wdata  = r_m_wdata;
    assign m_wstrb  = r_m_wstrb;

endmodule
`default_nettype wire

// File: tb/tb_mem_arb.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mem_arb
//  Purpose  : Self-checking bench for mem_arb (round-robin and fixed priority).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_mem_arb;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_req, d_req, d_we, m_ready, m_rvalid;
    logic [31:0] i_addr, d_addr, d_wdata, m_rdata;
    logic [3:0]  d_wstrb;

    logic        i_gnt, i_rvalid, d_gnt, d_rvalid, m_req, m_we;
    logic [31:0] i_rdata, d_rdata, m_addr, m_wdata;
    logic [3:0]  m_wstrb;

    logic        z_i_gnt, z_i_rvalid, z_d_gnt, z_d_rvalid, z_m_req, z_m_we;
    logic [31:0] z_i_rdata, z_d_rdata, z_m_addr, z_m_wdata;
    logic [3:0]  z_m_wstrb;

    always #5 clk = ~clk;

    mem_arb #(.AW(32), .DW(32), .RR(1)) dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_wstrb(d_wstrb),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata), .m_wstrb(m_wstrb),
        .m_ready(m_ready), .m_rvalid(m_rvalid), .m_rdata(m_rdata)
    );

    mem_arb #(.AW(32), .DW(32), .RR(0)) dut_fixed (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr), .i_gnt(z_i_gnt), .i_rvalid(z_i_rvalid), .i_rdata(z_i_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_wstrb(d_wstrb),
        .d_gnt(z_d_gnt), .d_rvalid(z_d_rvalid), .d_rdata(z_d_rdata),
        .m_req(z_m_req), .m_we(z_m_we), .m_addr(z_m_addr), .m_wdata(z_m_wdata), .m_wstrb(z_m_wstrb),
        .m_ready(m_ready), .m_rvalid(m_rvalid), .m_rdata(m_rdata)
    );

    int    n_checks = 0;
    int    n_fail   = 0;
    string ctx      = "init";

    typedef struct {
        bit          ireq;
        bit          dreq;
        bit          dwe;
        logic [31:0] iaddr;
        logic [31:0] daddr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic [3:0]  wstrb;
        bit          exp_d;   // round-robin instance grants d
        bit          exp_zd;  // fixed-priority instance grants d
    } vec_t;

    vec_t vt[8];
    vec_t vx;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s.%s: got %0h, expected %0h", ctx, nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        i_req = 1'b0; i_addr = '0;
        d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0; d_wstrb = '0;
        m_ready = 1'b0; m_rvalid = 1'b0; m_rdata = '0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        tick();
    endtask

    // One transaction against zero-wait memory, starting in an IDLE cycle.
    task automatic run_txn(input vec_t v);
        logic        dw;
        logic [31:0] eaddr;
        i_req = v.ireq; i_addr = v.iaddr;
        d_req = v.dreq; d_we = v.dwe; d_addr = v.daddr; d_wdata = v.wdata; d_wstrb = v.wstrb;
        m_ready = 1'b1; m_rvalid = 1'b0;
        #1;
        chk("i_gnt", i_gnt, !v.exp_d);
        chk("d_gnt", d_gnt, v.exp_d);
        chk("fixed_i_gnt", z_i_gnt, !v.exp_zd);
        chk("fixed_d_gnt", z_d_gnt, v.exp_zd);
        tick();
        i_req = 1'b0; d_req = 1'b0;
        #1;
        dw    = v.exp_d & v.dwe;
        eaddr = v.exp_d ? v.daddr : v.iaddr;
        chk("m_req", m_req, 1);
        chk("m_addr", m_addr, eaddr);
        chk("m_we", m_we, dw);
        chk("m_wdata", m_wdata, dw ? v.wdata : 32'h0);
        chk("m_wstrb", m_wstrb, dw ? v.wstrb : 4'h0);
        tick();
        m_rvalid = 1'b1; m_rdata = v.rdata;
        #1;
        chk("m_req_resp", m_req, 0);
        tick();
        m_rvalid = 1'b0;
        #1;
        chk("i_rvalid", i_rvalid, !v.exp_d);
        chk("d_rvalid", d_rvalid, v.exp_d);
        if (v.exp_d) chk("d_rdata", d_rdata, dw ? 32'h0 : v.rdata);
        else         chk("i_rdata", i_rdata, v.rdata);
        tick();
    endtask

    // Reference-model state for the randomized phase.
    bit          mb, macc, mown_d, mwe, mlast_d, prv, prv_d, ig_prev, dg_prev, ei, ed;
    logic [31:0] maddr, mwdata, mi_rdata, md_rdata;
    logic [3:0]  mwstrb;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vt[0] = '{1, 0, 0, 32'h100, 32'h0,    32'h0,        32'hDEADBEEF, 4'h0,    0, 0};
        vt[1] = '{1, 1, 0, 32'h104, 32'h3000, 32'h0,        32'h11111111, 4'h0,    1, 1};
        vt[2] = '{1, 1, 0, 32'h108, 32'h3004, 32'h0,        32'h22222222, 4'h0,    0, 1};
        vt[3] = '{1, 1, 0, 32'h10C, 32'h3008, 32'h0,        32'h33333333, 4'h0,    1, 1};
        vt[4] = '{0, 1, 0, 32'h0,   32'h300C, 32'h0,        32'h44444444, 4'h0,    1, 1};
        vt[5] = '{1, 1, 0, 32'h110, 32'h3010, 32'h0,        32'h55555555, 4'h0,    0, 1};
        vt[6] = '{0, 1, 1, 32'h0,   32'h3014, 32'hCAFEF00D, 32'h66666666, 4'b0101, 1, 1};
        vt[7] = '{1, 0, 0, 32'h114, 32'h0,    32'h0,        32'h77777777, 4'h0,    0, 0};

        // Reset with requests and a stray response present.
        ctx = "reset";
        clear_inputs();
        rst = 1'b0;
        i_req = 1'b1; d_req = 1'b1; m_ready = 1'b1; m_rvalid = 1'b1; m_rdata = '1;
        repeat (3) tick();
        #1;
        chk("i_gnt", i_gnt, 0);       chk("d_gnt", d_gnt, 0);
        chk("i_rvalid", i_rvalid, 0); chk("d_rvalid", d_rvalid, 0);
        chk("i_rdata", i_rdata, 0);   chk("d_rdata", d_rdata, 0);
        chk("m_req", m_req, 0);       chk("m_we", m_we, 0);
        chk("m_addr", m_addr, 0);     chk("m_wdata", m_wdata, 0);
        chk("m_wstrb", m_wstrb, 0);   chk("fixed_d_gnt", z_d_gnt, 0);
        tick();
        rst = 1'b1; i_req = 1'b0; d_req = 1'b0;
        #1;
        chk("post_i_rvalid", i_rvalid, 0); chk("post_d_rvalid", d_rvalid, 0);
        tick();
        #1;
        chk("idle_i_rvalid", i_rvalid, 0); chk("idle_d_rvalid", d_rvalid, 0);
        chk("idle_m_req", m_req, 0);
        m_rvalid = 1'b0;
        tick();

        ctx = "table";
        for (int k = 0; k < 8; k++) run_txn(vt[k]);

        // Store with memory stalling m_ready for three cycles.
        ctx = "store_wait";
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h2004; d_wdata = 32'h12345678; d_wstrb = 4'b0011;
        m_ready = 1'b0;
        #1;
        chk("d_gnt", d_gnt, 1); chk("i_gnt", i_gnt, 0);
        tick();
        d_req = 1'b0;
        for (int c = 0; c < 4; c++) begin
            m_ready = (c == 3);
            #1;
            chk("m_req", m_req, 1);          chk("m_we", m_we, 1);
            chk("m_addr", m_addr, 32'h2004); chk("m_wdata", m_wdata, 32'h12345678);
            chk("m_wstrb", m_wstrb, 4'b0011);
            tick();
        end
        m_ready = 1'b0; m_rvalid = 1'b1; m_rdata = 32'hFFFFFFFF;
        #1;
        chk("m_req_drop", m_req, 0);
        tick();
        m_rvalid = 1'b0;
        #1;
        chk("d_rvalid", d_rvalid, 1);      chk("d_rdata", d_rdata, 0);
        chk("i_rvalid", i_rvalid, 0);      chk("i_rdata_hold", i_rdata, 32'h77777777);
        tick();
        #1;
        chk("d_rvalid_pulse", d_rvalid, 0);
        tick();

        // Stray response in IDLE, then reset during RESP.
        ctx = "stray_rst";
        m_rvalid = 1'b1;
        tick();
        tick();
        m_rvalid = 1'b0;
        #1;
        chk("i_rvalid", i_rvalid, 0); chk("d_rvalid", d_rvalid, 0); chk("m_req", m_req, 0);
        tick();
        i_req = 1'b1; i_addr = 32'h200; m_ready = 1'b1;
        #1;
        chk("i_gnt", i_gnt, 1);
        tick();
        i_req = 1'b0;
        #1;
        chk("m_req", m_req, 1);
        tick();
        rst = 1'b0;
        #1;
        chk("rst_m_addr", m_addr, 0); chk("rst_m_req", m_req, 0);
        tick();
        rst = 1'b1; m_rvalid = 1'b1; m_rdata = 32'hBAD;
        #1;
        chk("rel_i_rvalid", i_rvalid, 0); chk("rel_d_rvalid", d_rvalid, 0);
        tick();
        #1;
        chk("late_i_rvalid", i_rvalid, 0); chk("late_d_rvalid", d_rvalid, 0);
        chk("late_i_rdata", i_rdata, 0);
        m_rvalid = 1'b0;
        tick();
        ctx = "after_rst";
        vx = '{0, 1, 0, 32'h0, 32'h400, 32'h0, 32'h0BADF00D, 4'h0, 1, 1};
        run_txn(vx);

        // Slow response with a fetch waiting behind a load.
        ctx = "rvalid_wait";
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h500; m_ready = 1'b1;
        #1;
        chk("d_gnt", d_gnt, 1);
        tick();
        d_req = 1'b0; i_req = 1'b1; i_addr = 32'h600;
        #1;
        chk("i_gnt_req", i_gnt, 0);
        tick();
        m_ready = 1'b0;
        for (int c = 0; c < 6; c++) begin
            m_rvalid = (c == 5);
            m_rdata  = 32'hA5A5A5A5;
            #1;
            chk("i_gnt_resp", i_gnt, 0); chk("d_rvalid_early", d_rvalid, 0);
            tick();
        end
        m_rvalid = 1'b0;
        #1;
        chk("d_rvalid", d_rvalid, 1); chk("d_rdata", d_rdata, 32'hA5A5A5A5);
        chk("i_gnt_after", i_gnt, 1);
        tick();
        i_req = 1'b0; m_ready = 1'b1;
        #1;
        chk("m_req", m_req, 1); chk("m_addr", m_addr, 32'h600);
        tick();
        m_rvalid = 1'b1; m_rdata = 32'h1234;
        tick();
        m_rvalid = 1'b0;
        #1;
        chk("i_rvalid", i_rvalid, 1); chk("i_rdata", i_rdata, 32'h1234);
        tick();

        // Continuous tie: round-robin alternates starting with i, fixed picks d.
        ctx = "tie";
        do_reset();
        i_req = 1'b1; d_req = 1'b1; d_we = 1'b0; m_ready = 1'b1; m_rvalid = 1'b1;
        for (int k = 0; k < 12; k++) begin
            m_rdata = 32'hC0DE0000 + k;
            i_addr  = 32'h700 + k;
            d_addr  = 32'h800 + k;
            #1;
            if (k % 3 == 0) begin
                chk("i_gnt", i_gnt, ((k / 3) % 2) == 0);
                chk("d_gnt", d_gnt, ((k / 3) % 2) == 1);
                chk("fixed_d_gnt", z_d_gnt, 1);
                chk("fixed_i_gnt", z_i_gnt, 0);
                if (k >= 3) begin
                    chk("i_rvalid", i_rvalid, ((k / 3 - 1) % 2) == 0);
                    chk("d_rvalid", d_rvalid, ((k / 3 - 1) % 2) == 1);
                    if (((k / 3 - 1) % 2) == 0) chk("i_rdata", i_rdata, 32'hC0DE0000 + k - 1);
                    else                        chk("d_rdata", d_rdata, 32'hC0DE0000 + k - 1);
                end
            end else begin
                chk("i_gnt_busy", i_gnt, 0);
                chk("d_gnt_busy", d_gnt, 0);
            end
            tick();
        end

        // Randomized traffic against a transaction-level model.
        ctx = "random";
        do_reset();
        mb = 0; macc = 0; mown_d = 0; mwe = 0; mlast_d = 1; prv = 0; prv_d = 0;
        ig_prev = 0; dg_prev = 0;
        maddr = '0; mwdata = '0; mwstrb = '0; mi_rdata = '0; md_rdata = '0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            if (!i_req || ig_prev) begin
                i_req = ($urandom % 3 == 0); i_addr = $urandom;
            end else if ($urandom % 8 == 0) begin
                i_req = 1'b0;
            end
            if (!d_req || dg_prev) begin
                d_req = ($urandom % 3 == 0); d_we = $urandom % 2;
                d_addr = $urandom; d_wdata = $urandom; d_wstrb = $urandom;
            end else if ($urandom % 8 == 0) begin
                d_req = 1'b0;
            end
            m_ready = $urandom % 2; m_rvalid = ($urandom % 3 == 0); m_rdata = $urandom;
            #1;
            ei = 0; ed = 0;
            if (!mb) begin
                if (i_req && d_req) begin
                    ei = mlast_d; ed = !mlast_d;
                end else begin
                    ei = i_req; ed = d_req;
                end
            end
            chk("i_gnt", i_gnt, ei);
            chk("d_gnt", d_gnt, ed);
            chk("m_req", m_req, mb && !macc);
            if (mb && !macc) begin
                chk("m_addr", m_addr, maddr);   chk("m_we", m_we, mwe);
                chk("m_wdata", m_wdata, mwdata); chk("m_wstrb", m_wstrb, mwstrb);
            end
            chk("i_rvalid", i_rvalid, prv && !prv_d);
            chk("d_rvalid", d_rvalid, prv && prv_d);
            chk("i_rdata", i_rdata, mi_rdata);
            chk("d_rdata", d_rdata, md_rdata);
            ig_prev = ei; dg_prev = ed; prv = 0;
            if (!mb) begin
                if (ei || ed) begin
                    mb = 1; macc = 0; mown_d = ed; mlast_d = ed;
                    if (ed) begin
                        mwe = d_we; maddr = d_addr;
                        mwdata = d_we ? d_wdata : 32'h0; mwstrb = d_we ? d_wstrb : 4'h0;
                    end else begin
                        mwe = 0; maddr = i_addr; mwdata = '0; mwstrb = '0;
                    end
                end
            end else if (!macc) begin
                if (m_ready) macc = 1;
            end else if (m_rvalid) begin
                mb = 0; prv = 1; prv_d = mown_d;
                if (mown_d) md_rdata = mwe ? 32'h0 : m_rdata;
                else        mi_rdata = m_rdata;
            end
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
